sdio_cmd_response_tx: RTL and testbench
=======================================

Name: sdio_cmd_response_tx

Overview:
Downstream stage of the SDIO command processor. Takes a 38-bit response payload (6-bit index/reserved field plus 32-bit argument) and a one-cycle strobe. Serialises it onto the SDIO CMD line as a standard 48-bit card-to-host response frame, generating CRC7 on the fly. Reports busy back to the processor so that data-line transfers start only after the response has finished.

Parameters:
- NCR_CYCLES, 2: idle clocks with the CMD line released between strobe acceptance and the start bit (Ncr). Legal range 2..63.
- R4_CRC_ONES, 1: when 1, a payload with index field 6'h3F is sent with the CRC field forced to 7'h7F (R4 format). When 0, CRC7 is always computed.

Ports:
- clock  in  1  SDIO clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- write_data  in  38  [37:32] index/reserved, [31:0] argument.
- write_data_strobe  in  1  one-cycle request to send write_data.
- cmd_out  out  1  serial CMD line value, MSB first.
- cmd_oe  out  1  CMD line output enable; the line is released when 0.
- send_command_in_progress  out  1  high from acceptance until the end bit has been driven.
- response_dropped  out  1  one-cycle pulse when a strobe arrives while busy.

Behaviour:
- Reset values: cmd_out=1, cmd_oe=0, send_command_in_progress=0, response_dropped=0, state=IDLE, counters=0, CRC=0. Reset asserted mid-frame aborts immediately: cmd_oe drops asynchronously and the frame is not resumed.
- States: IDLE -> WAIT_NCR -> SEND -> IDLE. With the optional feature compiled in, a PRE state sits between WAIT_NCR and SEND.
- IDLE:
  - Strobe at edge k latches write_data into a 38-bit shift register.
  - send_command_in_progress becomes 1 after edge k.
  - Wait counter loads NCR_CYCLES-1; state -> WAIT_NCR.
- WAIT_NCR:
  - cmd_oe=0, cmd_out=1.
  - Counter decrements each clock; at 0 -> SEND (or PRE).
  - The first frame bit is driven after edge k+NCR_CYCLES.
- SEND: 48 consecutive clocks with cmd_oe=1.
  - bit47 start=0.
  - bit46 transmission=0.
  - bits45..40 = write_data[37:32].
  - bits39..8 = write_data[31:0].
  - bits7..1 = CRC7.
  - bit0 end=1.
- CRC7:
  - Polynomial x^7+x^3+1, initial 0, computed serially over bits 47..8 (40 bits) as they are driven.
  - Forced to 7'h7F when R4_CRC_ONES=1 and index field = 6'h3F.
- Bit counter: 6 bits, counts 47 down to 0.
- After the end-bit cycle:
  - cmd_oe=0 and send_command_in_progress=0 on the next edge.
  - State -> IDLE. A new strobe may be accepted on that same edge.
- Strobe while busy (any state other than IDLE):
  - The payload is ignored and the active frame is unaffected.
  - response_dropped pulses for 1 clock.
- Strobe in the same cycle the FSM returns to IDLE: this counts as busy, so the strobe is dropped.
- Back-to-back responses: minimum spacing is NCR_CYCLES+48+1 clocks between accepted strobes.

Optional Feature:
- Macro: SDIO_RESP_PREAMBLE_EN.
- When defined:
  - A PRE state drives cmd_oe=1, cmd_out=1 for exactly 1 clock before the start bit.
  - The start bit moves to edge k+NCR_CYCLES+1.
  - cmd_oe is high for 49 clocks per frame.
- When undefined: no PRE state; cmd_oe is high for exactly 48 clocks.

Test Plan:
- Reset, then strobe with write_data = {6'h11, 32'h00000900}, NCR_CYCLES=2:
  - First driven bit appears 2 clocks after the strobe edge.
  - Serial stream is 0x11 00 00 09 00, then CRC 7'b0110011, end bit 1.
  - cmd_oe high for 48 clocks, then 0.
- Strobe with {6'h3F, 32'h80300000} (R4) and R4_CRC_ONES=1:
  - CRC bits are all 1 (7'h7F).
  - Repeat with R4_CRC_ONES=0: the computed CRC7 matches the bench model.
- Second strobe 10 clocks into a frame:
  - response_dropped pulses once.
  - The first frame completes unchanged.
  - send_command_in_progress stays high continuously until after the end bit.
- Assert reset at bit 20 of a frame:
  - cmd_oe=0 and send_command_in_progress=0 immediately.
  - After release, a new strobe produces a complete correct frame.
- Strobe exactly on the edge the FSM returns to IDLE, then another strobe 1 clock later:
  - The first is dropped; the second is accepted.
  - The frame starts NCR_CYCLES later.
- With SDIO_RESP_PREAMBLE_EN defined:
  - One cmd_oe=1/cmd_out=1 cycle precedes the start bit.
  - Total cmd_oe duration is 49 clocks.
  - Frame content is identical to the first scenario.

Source files
------------

// File: rtl/sdio_cmd_response_tx.sv
`default_nettype none
// ============================================================================
// Module   : sdio_cmd_response_tx
// Purpose  : Serialises a 38-bit SDIO response payload onto the CMD line as a
//            48-bit card-to-host frame (start, transmission, index, argument,
//            CRC7, end), honouring the Ncr gap and reporting busy status.
// Options  : define SDIO_RESP_PREAMBLE_EN to drive one idle-high cycle with the
//            line enabled immediately before the start bit.
// Revision : 1.0 - initial release
// ============================================================================
module sdio_cmd_response_tx #(
  parameter int NCR_CYCLES  = 2,
  parameter int R4_CRC_ONES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [37:0] write_data,
  input  logic        write_data_strobe,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        send_command_in_progress,
  output logic        response_dropped
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_NCR = 2'd1,
    S_PRE      = 2'd2,
    S_SEND     = 2'd3
  } state_t;

  localparam logic [5:0] c_ncr_load = 6'(NCR_CYCLES - 1);
  localparam logic [5:0] c_start_idx = 6'd47;

  state_t      r_state;
  logic [5:0]  r_wait_cnt;
  logic [5:0]  r_bit_cnt;
  logic [37:0] r_shift;
  logic [6:0]  r_crc;
  logic        r_r4;

  logic [5:0]  w_next_idx;
  logic [2:0]  w_crc_sel;
  logic [6:0]  w_crc_tx;
  logic        w_next_bit;
  logic        w_shift_en;
  logic        w_crc_en;

  // One serial step of CRC7 (x^7 + x^3 + 1).
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign w_next_idx = r_bit_cnt - 6'd1;
  assign w_crc_sel  = w_next_idx[2:0] - 3'd1;
  // R4 responses carry an all-ones CRC field instead of a real CRC.
  assign w_crc_tx   = r_r4 ? 7'h7F : r_crc;

  // Select the value of the next frame bit from its position in the frame.
  always_comb begin
    w_next_bit = 1'b1;
    w_shift_en = 1'b0;
    w_crc_en   = 1'b0;
    if (w_next_idx >= 6'd46) begin
      w_next_bit = 1'b0;
      w_crc_en   = 1'b1;
    end else if (w_next_idx >= 6'd8) begin
      w_next_bit = r_shift[37];
      w_shift_en = 1'b1;
      w_crc_en   = 1'b1;
    end else if (w_next_idx >= 6'd1) begin
      w_next_bit = w_crc_tx[w_crc_sel];
    end
  end

  // Response FSM with registered line outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state                  <= S_IDLE;
      r_wait_cnt               <= 6'd0;
      r_bit_cnt                <= 6'd0;
      r_shift                  <= 38'd0;
      r_crc                    <= 7'd0;
      r_r4                     <= 1'b0;
      cmd_out                  <= 1'b1;
      cmd_oe                   <= 1'b0;
      send_command_in_progress <= 1'b0;
      response_dropped         <= 1'b0;
    end else begin
      // Any strobe outside IDLE (including the return-to-IDLE edge) is lost.
      response_dropped <= write_data_strobe && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (write_data_strobe) begin
            r_shift                  <= write_data;
            r_r4                     <= (R4_CRC_ONES != 0) && (write_data[37:32] == 6'h3F);
            r_crc                    <= 7'd0;
            r_wait_cnt               <= c_ncr_load;
            send_command_in_progress <= 1'b1;
            r_state                  <= S_WAIT_NCR;
          end
        end
        S_WAIT_NCR: begin
          cmd_oe  <= 1'b0;
          cmd_out <= 1'b1;
          if (r_wait_cnt != 6'd0) begin
            r_wait_cnt <= r_wait_cnt - 6'd1;
          end else begin
`ifdef SDIO_RESP_PREAMBLE_EN
            cmd_oe  <= 1'b1;
            r_state <= S_PRE;
`else
            cmd_oe    <= 1'b1;
            cmd_out   <= 1'b0;
            r_bit_cnt <= c_start_idx;
            r_crc     <= crc7_step(r_crc, 1'b0);
            r_state   <= S_SEND;
`endif
          end
        end
`ifdef SDIO_RESP_PREAMBLE_EN
        S_PRE: begin
          cmd_oe    <= 1'b1;
          cmd_out   <= 1'b0;
          r_bit_cnt <= c_start_idx;
          r_crc     <= crc7_step(r_crc, 1'b0);
          r_state   <= S_SEND;
        end
`endif
        S_SEND: begin
          if (r_bit_cnt == 6'd0) begin
            cmd_oe                   <= 1'b0;
            cmd_out                  <= 1'b1;
            send_command_in_progress <= 1'b0;
            r_state                  <= S_IDLE;
          end else begin
            cmd_out   <= w_next_bit;
            r_bit_cnt <= w_next_idx;
            if (w_shift_en) r_shift <= {r_shift[36:0], 1'b0};
            if (w_crc_en)   r_crc   <= crc7_step(r_crc, w_next_bit);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdio_cmd_response_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdio_cmd_response_tx
// Purpose  : Directed bench for sdio_cmd_response_tx; two instances share the
//            stimulus, one with R4 all-ones CRC and one with computed CRC.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdio_cmd_response_tx;

  localparam int NCR = 2;
`ifdef SDIO_RESP_PREAMBLE_EN
  localparam int PRE = 1;
`else
  localparam int PRE = 0;
`endif

  logic        clock;
  logic        reset;
  logic [37:0] write_data;
  logic        write_data_strobe;
  logic        out_a, oe_a, busy_a, drop_a;
  logic        out_b, oe_b, busy_b, drop_b;

  int tests = 0;
  int fails = 0;

  sdio_cmd_response_tx #(.NCR_CYCLES(NCR), .R4_CRC_ONES(1)) dut_a (
    .clock                    (clock),
    .reset                    (reset),
    .write_data               (write_data),
    .write_data_strobe        (write_data_strobe),
    .cmd_out                  (out_a),
    .cmd_oe                   (oe_a),
    .send_command_in_progress (busy_a),
    .response_dropped         (drop_a)
  );

  sdio_cmd_response_tx #(.NCR_CYCLES(NCR), .R4_CRC_ONES(0)) dut_b (
    .clock                    (clock),
    .reset                    (reset),
    .write_data               (write_data),
    .write_data_strobe        (write_data_strobe),
    .cmd_out                  (out_b),
    .cmd_oe                   (oe_b),
    .send_command_in_progress (busy_b),
    .response_dropped         (drop_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference frame: {start, tx, payload, CRC7 over the first 40 bits, end}.
  function automatic logic [47:0] model(input logic [37:0] d, input bit r4ones);
    logic [6:0]  c;
    logic [39:0] f;
    logic        fb;
    c = 7'd0;
    f = {2'b00, d};
    for (int i = 39; i >= 0; i--) begin
      fb = f[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    if (r4ones && d[37:32] == 6'h3F) c = 7'h7F;
    return {f, c, 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe one payload at the next edge and check the complete frame.
  task automatic run_frame(input logic [37:0] data, input logic [47:0] exp_a,
                           input logic [47:0] exp_b, input int drop_at,
                           input bit tail, input logic [37:0] tail_data,
                           input string tag);
    int          oe_cnt, first_oe, busy_low, drops;
    logic        oe_before, out_before;
    logic [47:0] fa, fb;
    oe_cnt = 0; first_oe = -1; busy_low = 0; drops = 0;
    oe_before = 1'bx; out_before = 1'bx; fa = '0; fb = '0;
    write_data        = data;
    write_data_strobe = 1'b1;
    @(negedge clock);
    write_data_strobe = 1'b0;
    chk($sformatf("%s_busy_acc", tag), {47'd0, busy_a}, 48'd1);
    chk($sformatf("%s_oe_acc", tag), {47'd0, oe_a}, 48'd0);
    for (int c = 1; c <= NCR + PRE + 47; c++) begin
      if (c == drop_at) begin
        write_data        = {6'h15, 32'hA5A5_5A5A};
        write_data_strobe = 1'b1;
      end else begin
        write_data_strobe = 1'b0;
      end
      @(negedge clock);
      if (oe_a) begin
        oe_cnt++;
        if (first_oe < 0) first_oe = c;
      end
      if (!busy_a) busy_low++;
      if (drop_a) drops++;
      if (c == NCR + PRE - 1) begin
        oe_before  = oe_a;
        out_before = out_a;
      end
      if (c >= NCR + PRE) begin
        fa = {fa[46:0], out_a};
        fb = {fb[46:0], out_b};
      end
    end
    if (tail) begin
      write_data        = tail_data;
      write_data_strobe = 1'b1;
    end else begin
      write_data_strobe = 1'b0;
    end
    @(negedge clock);
    chk($sformatf("%s_first_oe", tag), 48'(first_oe), 48'(NCR));
    chk($sformatf("%s_oe_before_start", tag), {47'd0, oe_before}, 48'(PRE));
    chk($sformatf("%s_out_before_start", tag), {47'd0, out_before}, 48'd1);
    chk($sformatf("%s_oe_count", tag), 48'(oe_cnt), 48'(48 + PRE));
    chk($sformatf("%s_busy_gap", tag), 48'(busy_low), 48'd0);
    chk($sformatf("%s_drops", tag), 48'(drops), (drop_at > 0) ? 48'd1 : 48'd0);
    chk($sformatf("%s_frame_a", tag), fa, exp_a);
    chk($sformatf("%s_frame_b", tag), fb, exp_b);
    chk($sformatf("%s_post_oe", tag), {47'd0, oe_a}, 48'd0);
    chk($sformatf("%s_post_busy", tag), {47'd0, busy_a}, 48'd0);
    chk($sformatf("%s_post_drop", tag), {47'd0, drop_a}, tail ? 48'd1 : 48'd0);
  endtask

  initial begin
    logic [37:0] d;
    reset             = 1'b1;
    write_data        = '0;
    write_data_strobe = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_out",  {47'd0, out_a},  48'd1);
    chk("rst_oe",   {47'd0, oe_a},   48'd0);
    chk("rst_busy", {47'd0, busy_a}, 48'd0);
    chk("rst_drop", {47'd0, drop_a}, 48'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Basic R1-style response with known CRC 0110011.
    d = {6'h11, 32'h0000_0900};
    run_frame(d, 48'h1100_0009_0067, 48'h1100_0009_0067, -1, 1'b0, '0, "s1");
    repeat (3) @(negedge clock);

    // R4 response: forced all-ones CRC on dut_a, computed CRC on dut_b.
    d = {6'h3F, 32'h8030_0000};
    run_frame(d, 48'h3F80_3000_00FF, model(d, 1'b0), -1, 1'b0, '0, "r4");
    repeat (2) @(negedge clock);

    // Strobe arriving 10 bits into a frame is dropped.
    d = {6'h05, 32'hDEAD_BEEF};
    run_frame(d, model(d, 1'b1), model(d, 1'b0), NCR + PRE + 10, 1'b0, '0, "drop");
    repeat (2) @(negedge clock);

    // Reset asserted while bit 20 is on the line.
    d = {6'h2A, 32'h1234_5678};
    write_data        = d;
    write_data_strobe = 1'b1;
    @(negedge clock);
    write_data_strobe = 1'b0;
    repeat (NCR + PRE + 27) @(negedge clock);
    chk("rstmid_oe_before", {47'd0, oe_a}, 48'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_oe",   {47'd0, oe_a},   48'd0);
    chk("rstmid_busy", {47'd0, busy_a}, 48'd0);
    chk("rstmid_oe_b", {47'd0, oe_b},   48'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("rstmid_idle_oe", {47'd0, oe_a}, 48'd0);
    d = {6'h08, 32'h0000_01AA};
    run_frame(d, model(d, 1'b1), model(d, 1'b0), -1, 1'b0, '0, "after_rst");
    repeat (2) @(negedge clock);

    // Strobe on the return-to-IDLE edge is dropped; the next one is taken.
    d = {6'h37, 32'h0102_0304};
    run_frame(d, model(d, 1'b1), model(d, 1'b0), -1, 1'b1, {6'h3F, 32'h00FF_8000}, "tail1");
    d = {6'h3F, 32'h00FF_8000};
    run_frame(d, model(d, 1'b1), model(d, 1'b0), -1, 1'b0, '0, "tail2");
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
